// File: rtl/turn_ctrl.sv
// Turn sequencer for a two-tank artillery duel: aim, shell flight, settle pause, game over.
// Optional macro TURN_TIMEOUT_EN adds a flight-duration limit that turns a stuck shell into a miss.
module turn_ctrl #(
    parameter logic [3:0] HP_INIT        = 4'd10,
    parameter logic [3:0] DMG            = 4'd2,
    parameter logic [7:0] SETTLE_FRAMES  = 8'd30,
    parameter logic [7:0] FLIGHT_TIMEOUT = 8'd255
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       fire_btn,
    input  logic       hitA,
    input  logic       hitB,
    input  logic       landedA,
    input  logic       landedB,
    output logic       shootA,
    output logic       shootB,
    output logic       activeTank,
    output logic [3:0] hpA,
    output logic [3:0] hpB,
    output logic       dmg_pulse,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {AIM, FLIGHT, SETTLE, OVER} state_t;

    state_t     state_q, state_d;
    logic       active_q, active_d;
    logic [3:0] hpa_q, hpa_d, hpb_q, hpb_d;
    logic       shoota_q, shoota_d, shootb_q, shootb_d;
    logic       dmg_q, dmg_d;
    logic       over_q, over_d;
    logic       winner_q, winner_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic       fire_prev_q;

    logic       fire_edge;
    logic       hit_act, land_act;
    logic [3:0] opp_hp, opp_hp_hit;
    logic       flight_timeout;

    assign fire_edge  = fire_btn & ~fire_prev_q;
    assign hit_act    = active_q ? hitB : hitA;
    assign land_act   = active_q ? landedB : landedA;
    assign opp_hp     = active_q ? hpa_q : hpb_q;
    assign opp_hp_hit = (opp_hp > DMG) ? (opp_hp - DMG) : 4'd0;

`ifdef TURN_TIMEOUT_EN
    logic [7:0] flight_cnt_q, flight_cnt_d;

    assign flight_timeout = (flight_cnt_q == FLIGHT_TIMEOUT - 8'd1);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) flight_cnt_q <= 8'd0;
        else          flight_cnt_q <= flight_cnt_d;
    end

    always_comb begin
        flight_cnt_d = 8'd0;
        if (state_q == FLIGHT) flight_cnt_d = flight_cnt_q + 8'd1;
    end
`else
    logic timeout_unused;
    assign timeout_unused = ^FLIGHT_TIMEOUT;
    assign flight_timeout = 1'b0;
`endif

    // NOTE: every next-state signal gets its default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        hpa_d        = hpa_q;
        hpb_d        = hpb_q;
        shoota_d     = shoota_q;
        shootb_d     = shootb_q;
        dmg_d        = 1'b0;
        over_d       = over_q;
        winner_d     = winner_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            AIM: begin
                if (fire_edge) begin
                    state_d  = FLIGHT;
                    shoota_d = ~active_q;
                    shootb_d = active_q;
                end
            end
            FLIGHT: begin
                if (hit_act || land_act || flight_timeout) begin
                    state_d      = SETTLE;
                    shoota_d     = 1'b0;
                    shootb_d     = 1'b0;
                    settle_cnt_d = SETTLE_FRAMES;
                    if (hit_act) begin
                        dmg_d = 1'b1;
                        if (active_q) hpa_d = opp_hp_hit;
                        else          hpb_d = opp_hp_hit;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= 8'd1) begin
                    settle_cnt_d = 8'd0;
                    if (opp_hp == 4'd0) begin
                        state_d  = OVER;
                        over_d   = 1'b1;
                        winner_d = active_q;
                    end else begin
                        state_d  = AIM;
                        active_d = ~active_q;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - 8'd1;
                end
            end
            OVER: begin
                shoota_d = 1'b0;
                shootb_d = 1'b0;
            end
            default: state_d = AIM;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= AIM;
            active_q     <= 1'b0;
            hpa_q        <= HP_INIT;
            hpb_q        <= HP_INIT;
            shoota_q     <= 1'b0;
            shootb_q     <= 1'b0;
            dmg_q        <= 1'b0;
            over_q       <= 1'b0;
            winner_q     <= 1'b0;
            settle_cnt_q <= 8'd0;
            fire_prev_q  <= 1'b1;  // a button held through reset must not fire
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            hpa_q        <= hpa_d;
            hpb_q        <= hpb_d;
            shoota_q     <= shoota_d;
            shootb_q     <= shootb_d;
            dmg_q        <= dmg_d;
            over_q       <= over_d;
            winner_q     <= winner_d;
            settle_cnt_q <= settle_cnt_d;
            fire_prev_q  <= fire_btn;
        end
    end

    assign shootA     = shoota_q;
    assign shootB     = shootb_q;
    assign activeTank = active_q;
    assign hpA        = hpa_q;
    assign hpB        = hpb_q;
    assign dmg_pulse  = dmg_q;
    assign game_over  = over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl: main instance at default hit points, second instance (HP 9) for saturation and game over.
module tb_turn_ctrl;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;

    logic       fire_btn = 1'b0, hitA = 1'b0, hitB = 1'b0, landedA = 1'b0, landedB = 1'b0;
    logic       shootA, shootB, activeTank, dmg_pulse, game_over, winner;
    logic [3:0] hpA, hpB;

    logic       s_fire = 1'b0, s_hitA = 1'b0, s_hitB = 1'b0, s_landA = 1'b0, s_landB = 1'b0;
    logic       s_shootA, s_shootB, s_active, s_dmg, s_over, s_winner;
    logic [3:0] s_hpA, s_hpB;

    int checks = 0;
    int errors = 0;

    always #5 frame_clk = ~frame_clk;

    turn_ctrl #(.HP_INIT(4'd10), .DMG(4'd2), .SETTLE_FRAMES(8'd30), .FLIGHT_TIMEOUT(8'd5)) u_dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_btn(fire_btn),
        .hitA(hitA), .hitB(hitB), .landedA(landedA), .landedB(landedB),
        .shootA(shootA), .shootB(shootB), .activeTank(activeTank),
        .hpA(hpA), .hpB(hpB), .dmg_pulse(dmg_pulse), .game_over(game_over), .winner(winner)
    );

    turn_ctrl #(.HP_INIT(4'd9), .DMG(4'd2), .SETTLE_FRAMES(8'd2), .FLIGHT_TIMEOUT(8'd5)) u_sat (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .fire_btn(s_fire),
        .hitA(s_hitA), .hitB(s_hitB), .landedA(s_landA), .landedB(s_landB),
        .shootA(s_shootA), .shootB(s_shootB), .activeTank(s_active),
        .hpA(s_hpA), .hpB(s_hpB), .dmg_pulse(s_dmg), .game_over(s_over), .winner(s_winner)
    );

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        fire_btn = 1'b1;
        Reset_n  = 1'b0;
        tick(); tick();
        checks++;
        if ({shootA, shootB, activeTank, dmg_pulse, game_over, winner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000000", {shootA, shootB, activeTank, dmg_pulse, game_over, winner});
        end
        checks++;
        if (hpA !== 4'd10 || hpB !== 4'd10) begin
            errors++;
            $display("FAIL reset_hp got hpA=%0d hpB=%0d expected 10 10", hpA, hpB);
        end
        checks++;
        if (s_hpA !== 4'd9 || s_hpB !== 4'd9) begin
            errors++;
            $display("FAIL reset_hp_sat got %0d %0d expected 9 9", s_hpA, s_hpB);
        end
        Reset_n = 1'b1;
        tick(); tick();
        checks++;
        if (shootA !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_fire shootA got %b expected 0", shootA);
        end
    endtask

    task automatic test_fire_a();
        fire_btn = 1'b0; tick();
        fire_btn = 1'b1; tick();
        checks++;
        if (shootA !== 1'b1 || shootB !== 1'b0 || activeTank !== 1'b0) begin
            errors++;
            $display("FAIL fire_a got shootA=%b shootB=%b active=%b expected 1 0 0", shootA, shootB, activeTank);
        end
        fire_btn = 1'b0;
        hitB = 1'b1; landedB = 1'b1; tick();
        hitB = 1'b0; landedB = 1'b0;
        checks++;
        if (shootA !== 1'b1 || hpA !== 4'd10 || dmg_pulse !== 1'b0) begin
            errors++;
            $display("FAIL inactive_ignored_a got shootA=%b hpA=%0d dmg=%b expected 1 10 0", shootA, hpA, dmg_pulse);
        end
    endtask

    task automatic test_hit_a();
        hitA = 1'b1; tick();
        hitA = 1'b0;
        checks++;
        if (hpB !== 4'd8 || dmg_pulse !== 1'b1 || shootA !== 1'b0) begin
            errors++;
            $display("FAIL hit_a got hpB=%0d dmg=%b shootA=%b expected 8 1 0", hpB, dmg_pulse, shootA);
        end
        tick();
        checks++;
        if (dmg_pulse !== 1'b0) begin
            errors++;
            $display("FAIL dmg_one_cycle got %b expected 0", dmg_pulse);
        end
        repeat (28) tick();
        checks++;
        if (activeTank !== 1'b0) begin
            errors++;
            $display("FAIL settle_early got active=%b expected 0", activeTank);
        end
        tick();
        checks++;
        if (activeTank !== 1'b1) begin
            errors++;
            $display("FAIL settle_expiry got active=%b expected 1", activeTank);
        end
    endtask

    task automatic test_b_turn();
        fire_btn = 1'b1; tick();
        fire_btn = 1'b0;
        checks++;
        if (shootB !== 1'b1 || shootA !== 1'b0) begin
            errors++;
            $display("FAIL fire_b got shootA=%b shootB=%b expected 0 1", shootA, shootB);
        end
        hitA = 1'b1; tick();
        hitA = 1'b0;
        checks++;
        if (shootB !== 1'b1 || hpB !== 4'd8 || dmg_pulse !== 1'b0) begin
            errors++;
            $display("FAIL inactive_ignored_b got shootB=%b hpB=%0d dmg=%b expected 1 8 0", shootB, hpB, dmg_pulse);
        end
        hitB = 1'b1; landedB = 1'b1; tick();
        hitB = 1'b0; landedB = 1'b0;
        checks++;
        if (hpA !== 4'd8 || dmg_pulse !== 1'b1 || shootB !== 1'b0) begin
            errors++;
            $display("FAIL hit_priority got hpA=%0d dmg=%b shootB=%b expected 8 1 0", hpA, dmg_pulse, shootB);
        end
        repeat (30) tick();
        checks++;
        if (activeTank !== 1'b0) begin
            errors++;
            $display("FAIL turn_back_a got active=%b expected 0", activeTank);
        end
    endtask

    task automatic test_hold_fire();
        fire_btn = 1'b1; tick();
        checks++;
        if (shootA !== 1'b1) begin
            errors++;
            $display("FAIL fire_a2 got shootA=%b expected 1", shootA);
        end
        landedA = 1'b1; tick();
        landedA = 1'b0;
        checks++;
        if (shootA !== 1'b0 || hpB !== 4'd8 || dmg_pulse !== 1'b0) begin
            errors++;
            $display("FAIL landed_a got shootA=%b hpB=%0d dmg=%b expected 0 8 0", shootA, hpB, dmg_pulse);
        end
        repeat (30) tick();
        repeat (3) tick();
        checks++;
        if (activeTank !== 1'b1 || shootB !== 1'b0) begin
            errors++;
            $display("FAIL held_fire_no_shot got active=%b shootB=%b expected 1 0", activeTank, shootB);
        end
        fire_btn = 1'b0; tick();
        fire_btn = 1'b1; tick();
        checks++;
        if (shootB !== 1'b1) begin
            errors++;
            $display("FAIL fresh_edge_b got shootB=%b expected 1", shootB);
        end
        fire_btn = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (shootB !== 1'b0 || activeTank !== 1'b0 || hpA !== 4'd10 || hpB !== 4'd10) begin
            errors++;
            $display("FAIL async_reset got shootB=%b active=%b hpA=%0d hpB=%0d expected 0 0 10 10", shootB, activeTank, hpA, hpB);
        end
        Reset_n = 1'b1;
        tick(); tick();
    endtask

`ifdef TURN_TIMEOUT_EN
    task automatic test_timeout();
        fire_btn = 1'b1; tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (shootA !== 1'b1) begin
                errors++;
                $display("FAIL timeout_hold cycle %0d got shootA=%b expected 1", i, shootA);
            end
        end
        tick();
        checks++;
        if (shootA !== 1'b0 || hpB !== 4'd10 || dmg_pulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop got shootA=%b hpB=%0d dmg=%b expected 0 10 0", shootA, hpB, dmg_pulse);
        end
        repeat (30) tick();
        checks++;
        if (activeTank !== 1'b1) begin
            errors++;
            $display("FAIL timeout_turn got active=%b expected 1", activeTank);
        end
        fire_btn = 1'b0;
    endtask
`endif

    task automatic test_game_over();
        logic [3:0] exp_hpb [5] = '{4'd7, 4'd5, 4'd3, 4'd1, 4'd0};
        for (int i = 0; i < 5; i++) begin
            s_fire = 1'b1; tick();
            s_fire = 1'b0;
            s_hitA = 1'b1; tick();
            s_hitA = 1'b0;
            checks++;
            if (s_hpB !== exp_hpb[i]) begin
                errors++;
                $display("FAIL sat_hit %0d got hpB=%0d expected %0d", i, s_hpB, exp_hpb[i]);
            end
            tick(); tick();
            if (i < 4) begin
                s_fire = 1'b1; tick();
                s_fire = 1'b0;
                s_landB = 1'b1; tick();
                s_landB = 1'b0;
                tick(); tick();
            end
        end
        checks++;
        if (s_over !== 1'b1 || s_winner !== 1'b0 || s_shootA !== 1'b0 || s_shootB !== 1'b0) begin
            errors++;
            $display("FAIL game_over got over=%b winner=%b shoot=%b%b expected 1 0 00", s_over, s_winner, s_shootA, s_shootB);
        end
        s_fire = 1'b1; tick();
        s_fire = 1'b0; tick();
        s_fire = 1'b1; s_hitA = 1'b1; tick();
        s_hitA = 1'b0; tick();
        checks++;
        if (s_shootA !== 1'b0 || s_shootB !== 1'b0 || s_hpB !== 4'd0 || s_over !== 1'b1) begin
            errors++;
            $display("FAIL over_absorbing got shoot=%b%b hpB=%0d over=%b expected 00 0 1", s_shootA, s_shootB, s_hpB, s_over);
        end
        s_fire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fire_a();
        test_hit_a();
        test_b_turn();
        test_hold_fire();
        test_reset_mid_flight();
`ifdef TURN_TIMEOUT_EN
        test_timeout();
`endif
        test_game_over();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
